// File: rtl/expr_check_sched.sv
// Round-robin scheduler that buffers one NUL-terminated frame per grant,
// replays it through a shared expression checker and reports the verdict.
module expr_check_sched #(
    parameter int NUM_SRC = 2,
    parameter int MAX_LEN = 16,
    localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [NUM_SRC-1:0]   src_valid,
    input  logic [8*NUM_SRC-1:0] src_data,
    output logic [NUM_SRC-1:0]   src_ready,
    output logic                 chk_clr,
    output logic [7:0]           chk_in,
    input  logic                 chk_out,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 res_ok,
    output logic                 res_err,
    output logic [SW-1:0]        res_src,
    output logic [LW-1:0]        res_len
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CLEAR, S_PLAY, S_SAMPLE, S_REPORT
    } state_t;

    state_t          r_state, w_next;
    logic [SW-1:0]   r_rr_ptr, r_grant, w_pick, w_cand;
    logic            w_any;
    logic [LW-1:0]   r_len, r_idx;
    logic            r_ovf, r_res_ok;
    logic [7:0]      r_buf [MAX_LEN];
    logic [7:0]      w_byte;
    logic            w_hs, w_store;

    // Arbiter: scan downward so the lowest offset from rr_ptr wins.
    always_comb begin
        w_any  = 1'b0;
        w_pick = r_rr_ptr;
        w_cand = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            w_cand = SW'((int'(r_rr_ptr) + i) % NUM_SRC);
            if (src_valid[w_cand]) begin
                w_any  = 1'b1;
                w_pick = w_cand;
            end
        end
    end

    assign w_byte  = src_data[{r_grant, 3'b000} +: 8];
    assign w_hs    = (r_state == S_LOAD) && src_valid[r_grant];
    assign w_store = w_hs && (w_byte != 8'h00) && (r_len < LW'(MAX_LEN));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_any) w_next = S_LOAD;
            S_LOAD: begin
                if (w_hs && (w_byte == 8'h00))
                    w_next = ((r_len == '0) || r_ovf) ? S_REPORT : S_CLEAR;
            end
            S_CLEAR:  w_next = S_PLAY;
            S_PLAY:   if (r_idx == r_len - LW'(1)) w_next = S_SAMPLE;
            S_SAMPLE: w_next = S_REPORT;
            S_REPORT: if (res_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        src_ready = '0;
        if (r_state == S_LOAD) src_ready[r_grant] = 1'b1;
        chk_clr   = clr || (r_state == S_CLEAR);
        chk_in    = (r_state == S_PLAY) ? r_buf[r_idx[AW-1:0]] : 8'h00;
        res_valid = (r_state == S_REPORT);
        res_ok    = res_valid && r_res_ok;
        res_err   = res_valid && r_ovf;
        res_src   = res_valid ? r_grant : '0;
        res_len   = res_valid ? r_len : '0;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_grant  <= '0;
            r_len    <= '0;
            r_idx    <= '0;
            r_ovf    <= 1'b0;
            r_res_ok <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant  <= w_pick;
                        r_len    <= '0;
                        r_ovf    <= 1'b0;
                        r_res_ok <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (w_store)
                        r_len <= r_len + LW'(1);
                    else if (w_hs && (w_byte != 8'h00))
                        r_ovf <= 1'b1;
                end
                S_CLEAR:  r_idx <= '0;
                S_PLAY:   r_idx <= r_idx + LW'(1);
                // chk_out already reflects the final character here.
                S_SAMPLE: r_res_ok <= chk_out;
                S_REPORT: begin
                    if (res_ready)
                        r_rr_ptr <= SW'((int'(r_grant) + 1) % NUM_SRC);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_store) r_buf[r_len[AW-1:0]] <= w_byte;
    end

endmodule
